// File: rtl/muldiv_iter_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with W-form support and a valid/ready handshake plus flush.
module muldiv_iter_unit #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned WLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            w,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST_X = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_W = CW'(WLEN - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_hold;
    logic              w_hold;
    logic              neg_hold;
    logic              neg_rem_hold;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] addend;
    logic [XLEN-1:0]   shreg;

    function automatic logic [XLEN-1:0] wfmt(input logic [XLEN-1:0] v, input logic wf);
        return wf ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
    endfunction

    // Request decode: effective operands, signs, magnitudes and the divide special cases.
    logic            is_div, w_eff, sgn_a, sgn_b, neg_a, neg_b, b_zero, div_ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, special_res;

    always_comb begin
        is_div = op[2];
        w_eff  = w & (op[2] | (op[1:0] == 2'd0));
        sgn_a  = op[2] ? ~op[0] : (op[1:0] != 2'd3);
        sgn_b  = op[2] ? ~op[0] : ~op[1];
        a_ext  = a;
        b_ext  = b;
        if (w_eff) begin
            a_ext = {{(XLEN-WLEN){sgn_a & a[WLEN-1]}}, a[WLEN-1:0]};
            b_ext = {{(XLEN-WLEN){sgn_b & b[WLEN-1]}}, b[WLEN-1:0]};
        end
        neg_a   = sgn_a & a_ext[XLEN-1];
        neg_b   = sgn_b & b_ext[XLEN-1];
        a_mag   = neg_a ? -a_ext : a_ext;
        b_mag   = neg_b ? -b_ext : b_ext;
        min_neg = w_eff ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                        : {1'b1, {(XLEN-1){1'b0}}};
        b_zero  = (b_ext == '0);
        div_ovf = sgn_b & (a_ext == min_neg) & (&b_ext);
        if (b_zero) begin
            special_res = op[1] ? wfmt(a_ext, w_eff) : '1;
        end else begin
            special_res = op[1] ? '0 : wfmt(a_ext, w_eff);
        end
    end

    // One iteration step, plus the signed/W-formatted result used on the final step.
    logic [XLEN:0]     rem_shift, rem_next;
    logic              quo_bit;
    logic [2*XLEN-1:0] acc_next, addend_next, prod;
    logic [XLEN-1:0]   shreg_next, quo_fin, rem_fin, done_res;

    always_comb begin
        rem_shift = {acc[XLEN-1:0], shreg[XLEN-1]};
        quo_bit   = rem_shift >= {1'b0, addend[XLEN-1:0]};
        rem_next  = quo_bit ? rem_shift - {1'b0, addend[XLEN-1:0]} : rem_shift;
        if (op_hold[2]) begin
            acc_next    = {{(XLEN-1){1'b0}}, rem_next};
            addend_next = addend;
            shreg_next  = {shreg[XLEN-2:0], quo_bit};
        end else begin
            acc_next    = acc + (shreg[0] ? addend : '0);
            addend_next = addend << 1;
            shreg_next  = shreg >> 1;
        end
        prod    = neg_hold ? -acc_next : acc_next;
        quo_fin = neg_hold ? -shreg_next : shreg_next;
        rem_fin = neg_rem_hold ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
        if (!op_hold[2]) begin
            done_res = (op_hold[1:0] == 2'd0) ? wfmt(prod[XLEN-1:0], w_hold)
                                              : prod[2*XLEN-1:XLEN];
        end else begin
            done_res = op_hold[1] ? wfmt(rem_fin, w_hold) : wfmt(quo_fin, w_hold);
        end
    end

    assign in_ready  = (state == IDLE) && !reset && !flush;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_hold      <= '0;
            w_hold       <= 1'b0;
            neg_hold     <= 1'b0;
            neg_rem_hold <= 1'b0;
            acc          <= '0;
            addend       <= '0;
            shreg        <= '0;
            result       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_hold      <= op;
                        w_hold       <= w_eff;
                        neg_hold     <= neg_a ^ neg_b;
                        neg_rem_hold <= neg_a;
                        acc          <= '0;
                        addend       <= {{XLEN{1'b0}}, b_mag};
                        // W divides run MSB-first, so park the dividend at the top.
                        shreg        <= (is_div && w_eff) ? a_mag << (XLEN - WLEN) : a_mag;
                        cnt          <= '0;
                        if (is_div && (b_zero || div_ovf)) begin
                            result <= special_res;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        acc    <= acc_next;
                        addend <= addend_next;
                        shreg  <= shreg_next;
                        cnt    <= cnt + CW'(1);
                        if (cnt == (w_hold ? LAST_W : LAST_X)) begin
                            state  <= DONE;
                            result <= done_res;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit: directed literal cases plus randomized ops checked every cycle
// against an arithmetic reference model.
module tb_muldiv_iter_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, w, flush, out_valid, out_ready;
    logic [2:0]  op;
    logic [63:0] a, b, result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          mon_en = 1'b0;
    bit          pend = 1'b0;
    logic [63:0] exp_res;
    int          exp_cyc;
    int          mon_lat;
    logic        mon_ir, mon_ov;

    bit or_force = 1'b1;
    bit bp_rand = 1'b0;

    muldiv_iter_unit #(.XLEN(64), .WLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .w(w),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_force;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain wide arithmetic on the effective operands; lat is iteration cycles.
    function automatic void model(input logic [2:0] m_op, input logic m_w,
                                  input logic [63:0] m_a, input logic [63:0] m_b,
                                  output logic [63:0] m_res, output int m_lat);
        logic weff;
        logic signed [129:0] pa, pb, p;
        logic signed [64:0] da, db, q, r, mn;
        logic [63:0] raw;
        weff = m_w && !(m_op >= 3'd1 && m_op <= 3'd3);
        m_lat = weff ? 32 : 64;
        if (!m_op[2]) begin
            if (weff) begin
                pa = $signed(m_a[31:0]);
                pb = $signed(m_b[31:0]);
            end else begin
                if (m_op != 3'd3) pa = $signed(m_a); else pa = $signed({66'd0, m_a});
                if (m_op <= 3'd1) pb = $signed(m_b); else pb = $signed({66'd0, m_b});
            end
            p = pa * pb;
            raw = (m_op == 3'd0) ? p[63:0] : p[127:64];
        end else begin
            if (!m_op[0]) begin
                if (weff) begin da = $signed(m_a[31:0]); db = $signed(m_b[31:0]); end
                else begin da = $signed(m_a); db = $signed(m_b); end
            end else begin
                if (weff) begin
                    da = $signed({33'd0, m_a[31:0]}); db = $signed({33'd0, m_b[31:0]});
                end else begin
                    da = $signed({1'b0, m_a}); db = $signed({1'b0, m_b});
                end
            end
            mn = -(65'sd1 <<< (weff ? 31 : 63));
            if (db == 0) begin
                q = -65'sd1;
                r = da;
                m_lat = 0;
            end else begin
                q = da / db;
                r = da % db;
                if (!m_op[0] && db == -65'sd1 && da == mn) m_lat = 0;
            end
            raw = m_op[1] ? r[63:0] : q[63:0];
        end
        m_res = weff ? {{32{raw[31]}}, raw[31:0]} : raw;
    endfunction

    // Cycle-by-cycle compare of handshake, latency and result against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_ir = !pend && !reset && !flush;
            mon_ov = pend && (cyc >= exp_cyc);
            chk("in_ready", {63'd0, in_ready}, {63'd0, mon_ir});
            chk("out_valid", {63'd0, out_valid}, {63'd0, mon_ov});
            if (out_valid && pend) chk("result", result, exp_res);
            if (reset || flush) begin
                pend = 1'b0;
            end else if (pend && out_valid && out_ready) begin
                pend = 1'b0;
            end else if (!pend && in_valid && mon_ir) begin
                model(op, w, a, b, exp_res, mon_lat);
                exp_cyc = cyc + 1 + mon_lat;
                pend = 1'b1;
            end
        end
    end

    task automatic issue(input logic [2:0] i_op, input logic i_w,
                         input logic [63:0] i_a, input logic [63:0] i_b);
        bit ok = 1'b0;
        in_valid = 1'b1; op = i_op; w = i_w; a = i_a; b = i_b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout: actual=no_accept required=accept");
        end
        // Operands are don't-care after accept; scramble them.
        in_valid = 1'b0;
        op = 3'($urandom);
        w = 1'($urandom);
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!pend) break;
            @(posedge clk); #1;
        end
        checks++;
        if (pend) begin
            failures++;
            $display("FAIL idle_timeout: actual=pending required=idle");
        end
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_dir(input string nm, input logic [2:0] d_op, input logic d_w,
                           input logic [63:0] d_a, input logic [63:0] d_b,
                           input logic [63:0] lit, input int lit_cycles);
        logic [63:0] mr;
        int ml, n;
        model(d_op, d_w, d_a, d_b, mr, ml);
        chk({nm, "_model"}, mr, lit);
        issue(d_op, d_w, d_a, d_b);
        wait_valid(n);
        chk({nm, "_cycles"}, 64'(n + 1), 64'(lit_cycles));
        chk(nm, result, lit);
        wait_idle(200);
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 20));
            4: return {$urandom(), 32'h8000_0000};
            5: return {$urandom(), 32'hFFFF_FFFF};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [63:0] held;
        int n;
        bit ov_seen;
        reset = 1'b1; in_valid = 1'b0; op = '0; w = 1'b0; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_dir("mul_7x-3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                64'hFFFF_FFFF_FFFF_FFEB, 65);
        run_dir("mulhu_ones", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_dir("mulh_ones", 3'd1, 1'b0, '1, '1, 64'd0, 65);
        run_dir("mulhsu_ones", 3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_dir("div_by0", 3'd4, 1'b0, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_dir("rem_by0", 3'd6, 1'b0, 64'd10, 64'd0, 64'd10, 1);
        run_dir("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1,
                64'h8000_0000_0000_0000, 1);
        run_dir("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_dir("divw", 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_dir("remw", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_dir("divuw", 3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
                64'hFFFF_FFFF_FFFF_FFFF, 33);

        // Backpressure: result and in_ready held while out_ready is low.
        or_force = 1'b0;
        issue(3'd5, 1'b0, 64'd1000, 64'd3);
        wait_valid(n);
        held = result;
        chk("bp_result", held, 64'd333);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", result, held);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        or_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        run_dir("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        // Flush on the 10th busy cycle of a DIV.
        issue(3'd4, 1'b0, -64'd1000, 64'd7);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        ov_seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (out_valid) ov_seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_valid", {63'd0, ov_seen}, 64'd0);
        @(posedge clk); #1;
        run_dir("mul_3x5", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 65);

        // Reset while holding a result in DONE.
        or_force = 1'b0;
        issue(3'd0, 1'b0, 64'd123, 64'd456);
        wait_valid(n);
        chk("pre_reset_result", result, 64'd56088);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        reset = 1'b0;
        or_force = 1'b1;
        @(posedge clk); #1;

        // Randomized ops with random backpressure and occasional flushes.
        bp_rand = 1'b1;
        for (int t = 0; t < 250; t++) begin
            issue(3'($urandom), 1'($urandom), rnd_opnd(), rnd_opnd());
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
            wait_idle(400);
        end
        bp_rand = 1'b0;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
